// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: load-use and HI/LO-busy stalls, branch flushes,
// MDU busy tracking and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MDU_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rsID,
    input  logic [4:0]  rtID,
    input  logic        useRs,
    input  logic        useRt,
    input  logic [4:0]  rdEX,
    input  logic        lwEX,
    input  logic        GPRWrEX,
    input  logic        branchEX,
    input  logic        mdStartEX,
    input  logic        mdUseID,
    output logic        PCWr,
    output logic        IFIDWr,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        mdBusy,
    output logic [15:0] stallCnt
);

    localparam logic [5:0] MdLat = 6'(MDU_LATENCY);

    typedef enum logic {
        StRun,
        StMdWait
    } md_state_e;

    md_state_e   md_state_q, md_state_d;
    logic [5:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic ld_haz;
    logic md_haz;
    logic stall;

    assign mdBusy   = (md_state_q == StMdWait);
    assign stallCnt = stall_cnt_q;

    // Hazard detection and pipeline control with branch > stall > normal priority.
    always_comb begin
        ld_haz    = lwEX && GPRWrEX && (rdEX != 5'd0) &&
                    ((useRs && (rsID == rdEX)) || (useRt && (rtID == rdEX)));
        md_haz    = mdUseID && mdBusy;
        stall     = (ld_haz || md_haz) && !branchEX;
        PCWr      = 1'b1;
        IFIDWr    = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        if (branchEX) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (stall) begin
            PCWr      = 1'b0;
            IFIDWr    = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

    // MDU busy FSM; a start while waiting reloads the latency counter.
    always_comb begin
        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        unique case (md_state_q)
            StRun: begin
                if (mdStartEX) begin
                    md_state_d = StMdWait;
                    md_cnt_d   = MdLat;
                end
            end
            StMdWait: begin
                if (mdStartEX) begin
                    md_cnt_d = MdLat;
                end else if (md_cnt_q == 6'd1) begin
                    md_state_d = StRun;
                    md_cnt_d   = 6'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 6'd1;
                end
            end
            default: begin
                md_state_d = StRun;
                md_cnt_d   = 6'd0;
            end
        endcase
    end

    // Stall counter holds at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state_q  <= StRun;
            md_cnt_q    <= 6'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            md_state_q  <= md_state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-indexed reference model.
module tb_hazard_ctrl;

    localparam int Lat = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rsID, rtID, rdEX;
    logic        useRs, useRt, lwEX, GPRWrEX, branchEX, mdStartEX, mdUseID;
    logic        PCWr, IFIDWr, IFIDFlush, IDEXFlush, mdBusy;
    logic [15:0] stallCnt;

    hazard_ctrl #(.MDU_LATENCY(Lat)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rsID      (rsID),
        .rtID      (rtID),
        .useRs     (useRs),
        .useRt     (useRt),
        .rdEX      (rdEX),
        .lwEX      (lwEX),
        .GPRWrEX   (GPRWrEX),
        .branchEX  (branchEX),
        .mdStartEX (mdStartEX),
        .mdUseID   (mdUseID),
        .PCWr      (PCWr),
        .IFIDWr    (IFIDWr),
        .IFIDFlush (IFIDFlush),
        .IDEXFlush (IDEXFlush),
        .mdBusy    (mdBusy),
        .stallCnt  (stallCnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current cycle index, last busy cycle, total stall count.
    int cyc        = 0;
    int busy_until = -1;
    int sc         = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_inputs();
        rsID = 0; rtID = 0; rdEX = 0;
        useRs = 0; useRt = 0; lwEX = 0; GPRWrEX = 0;
        branchEX = 0; mdStartEX = 0; mdUseID = 0;
    endtask

    task automatic model_reset();
        cyc        = 0;
        busy_until = -1;
        sc         = 0;
    endtask

    // One cycle: inputs already driven; check outputs mid-cycle, then advance the model.
    task automatic step();
        logic busy, ld, md, stl;
        logic e_pc, e_ifid, e_ifl, e_idl;
        busy = (cyc <= busy_until);
        ld   = lwEX && GPRWrEX && (rdEX != 0) &&
               ((useRs && rsID == rdEX) || (useRt && rtID == rdEX));
        md   = mdUseID && busy;
        stl  = (ld || md) && !branchEX;
        if (branchEX) begin
            e_pc = 1; e_ifid = 1; e_ifl = 1; e_idl = 1;
        end else if (stl) begin
            e_pc = 0; e_ifid = 0; e_ifl = 0; e_idl = 1;
        end else begin
            e_pc = 1; e_ifid = 1; e_ifl = 0; e_idl = 0;
        end
        @(negedge clk);
        check_eq("PCWr", 32'(PCWr), 32'(e_pc));
        check_eq("IFIDWr", 32'(IFIDWr), 32'(e_ifid));
        check_eq("IFIDFlush", 32'(IFIDFlush), 32'(e_ifl));
        check_eq("IDEXFlush", 32'(IDEXFlush), 32'(e_idl));
        check_eq("mdBusy", 32'(mdBusy), 32'(busy));
        check_eq("stallCnt", 32'(stallCnt), 32'(sc));
        @(posedge clk);
        if (stl && sc < 65535) sc++;
        if (mdStartEX) busy_until = cyc + Lat;
        cyc++;
        #1;
    endtask

    initial begin
        int base;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_PCWr", 32'(PCWr), 32'd1);
        check_eq("rst_IFIDWr", 32'(IFIDWr), 32'd1);
        check_eq("rst_IFIDFlush", 32'(IFIDFlush), 32'd0);
        check_eq("rst_IDEXFlush", 32'(IDEXFlush), 32'd0);
        check_eq("rst_mdBusy", 32'(mdBusy), 32'd0);
        check_eq("rst_stallCnt", 32'(stallCnt), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Load-use on rs.
        repeat (5) step();
        lwEX = 1; GPRWrEX = 1; rdEX = 8; rsID = 8; useRs = 1;
        step();
        clear_inputs();
        step();
        check_eq("lu_cnt", 32'(stallCnt), 32'd1);

        // $zero destination and unused operand: no stall.
        lwEX = 1; GPRWrEX = 1; rdEX = 0; rsID = 0; useRs = 1;
        step();
        lwEX = 1; GPRWrEX = 1; rdEX = 8; rsID = 8; useRs = 0; rtID = 3; useRt = 1;
        step();
        clear_inputs();
        step();
        check_eq("zero_cnt", 32'(stallCnt), 32'd1);

        // MDU wait: start, then a HI/LO user held in ID.
        base = sc;
        mdStartEX = 1;
        step();
        mdStartEX = 0; mdUseID = 1;
        repeat (Lat) step();
        check_eq("md_free_pc", 32'(PCWr), 32'd1);
        step();
        clear_inputs();
        check_eq("md_cnt", 32'(stallCnt), 32'(base + Lat));

        // Branch overrides an active load-use hazard.
        base = sc;
        lwEX = 1; GPRWrEX = 1; rdEX = 9; rtID = 9; useRt = 1; branchEX = 1;
        step();
        clear_inputs();
        check_eq("br_cnt", 32'(stallCnt), 32'(base));

        // Asynchronous reset during the second MDWAIT cycle.
        mdStartEX = 1;
        step();
        mdStartEX = 0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_mdBusy", 32'(mdBusy), 32'd0);
        check_eq("arst_stallCnt", 32'(stallCnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        mdUseID = 1;
        step();
        clear_inputs();

        // Randomized traffic with narrow register ranges so hazards are frequent.
        for (int i = 0; i < 2000; i++) begin
            rsID      = 5'($urandom_range(0, 3));
            rtID      = 5'($urandom_range(0, 3));
            rdEX      = 5'($urandom_range(0, 3));
            useRs     = 1'($urandom_range(0, 1));
            useRt     = 1'($urandom_range(0, 1));
            lwEX      = 1'($urandom_range(0, 1));
            GPRWrEX   = ($urandom_range(0, 3) != 0);
            branchEX  = ($urandom_range(0, 7) == 0);
            mdStartEX = ($urandom_range(0, 11) == 0);
            mdUseID   = ($urandom_range(0, 2) == 0);
            step();
        end
        clear_inputs();
        step();

        // Saturation: long run of back-to-back load-use stalls.
        lwEX = 1; GPRWrEX = 1; rdEX = 5; rsID = 5; useRs = 1;
        repeat (65540) @(posedge clk);
        #1;
        sc  = (sc + 65540 > 65535) ? 65535 : sc + 65540;
        cyc = cyc + 65540;
        check_eq("sat_cnt", 32'(stallCnt), 32'h0000FFFF);
        step();
        step();
        clear_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock controller for the 5-stage MIPS32 datapath. It sits beside the forwarding unit in the ID/EX boundary and resolves the hazards forwarding cannot cover: load-use dependences and accesses to HI/LO while the multi-cycle multiply/divide unit is busy. It also flushes IF/ID and ID/EX on a taken branch resolved in EX. It drives the PC and pipeline-register write enables and flushes, and keeps a saturating stall-cycle performance counter.

## Interface
- MDU_LATENCY, 32, cycles the MDU stays busy after a mult/div issues from EX; legal range 1..63
- clk  input  1  pipeline clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- rsID  input  5  rs field of the instruction in ID
- rtID  input  5  rt field of the instruction in ID
- useRs  input  1  ID instruction reads rs
- useRt  input  1  ID instruction reads rt
- rdEX  input  5  destination register of the instruction in EX
- lwEX  input  1  EX instruction is a load
- GPRWrEX  input  1  EX instruction writes the GPR file
- branchEX  input  1  taken branch/jump redirect resolved in EX this cycle
- mdStartEX  input  1  mult/div in EX issues to the MDU this cycle
- mdUseID  input  1  ID instruction touches HI/LO (mfhi, mflo, mthi, mtlo, mult, div)
- PCWr  output  1  PC write enable
- IFIDWr  output  1  IF/ID register write enable
- IFIDFlush  output  1  zero IF/ID on the next edge
- IDEXFlush  output  1  insert a bubble into ID/EX on the next edge
- mdBusy  output  1  MDU result not yet available
- stallCnt  output  16  number of stall cycles since reset, saturating

## Operation
- The combinational hazard terms are:
  - ldHaz = lwEX & GPRWrEX & (rdEX != 0) & ((useRs & rsID == rdEX) | (useRt & rtID == rdEX))
  - mdHaz = mdUseID & mdBusy
  - stall = (ldHaz | mdHaz) & ~branchEX
- Outputs have fixed priorities:
  - Branch has the highest priority. When branchEX = 1: PCWr = 1, IFIDWr = 1, IFIDFlush = 1, IDEXFlush = 1. The stalled ID instruction is squashed, so no stall is counted.
  - When stall = 1: PCWr = 0, IFIDWr = 0, IFIDFlush = 0, IDEXFlush = 1.
  - Otherwise: PCWr = 1, IFIDWr = 1, and both flushes are 0.
- The MDU FSM has two states, RUN and MDWAIT, plus a counter mdCnt of width clog2(64).
  - RUN: when mdStartEX = 1, load mdCnt = MDU_LATENCY and go to MDWAIT.
  - MDWAIT: decrement mdCnt each cycle. When mdCnt reaches 1 and mdStartEX = 0, go to RUN next cycle with mdCnt = 0.
  - mdBusy = (state == MDWAIT).
  - mdStartEX while in MDWAIT reloads mdCnt = MDU_LATENCY and stays in MDWAIT. This is a protocol violation, because mdHaz prevents it, but the behaviour is defined.
- The load-use stall is combinational only and needs no state. After one bubble the load sits in MEM and the forwarding unit supplies it through the outMEM path, so ldHaz self-clears.
- stallCnt increments on every edge where stall = 1 and holds at 16'hFFFF.
- Register 0 never causes a load-use stall.

## Timing
- Reset (rst_n = 0, asynchronous): state = RUN, mdCnt = 0, mdBusy = 0, stallCnt = 0. With all inputs low, PCWr = 1, IFIDWr = 1, IFIDFlush = 0, IDEXFlush = 0.
- Stall and flush outputs are combinational from inputs and state, with zero-cycle latency, valid in the same cycle as the hazard.
- If mdStartEX is high in cycle T, mdBusy is high in cycles T+1 through T+MDU_LATENCY and low from T+MDU_LATENCY+1.
- An mdUseID instruction held in ID from cycle T+1 stalls through T+MDU_LATENCY and advances at the edge ending cycle T+MDU_LATENCY+1.
- Load-use costs exactly one stall cycle per dependent instruction.
- When ldHaz and mdHaz occur in the same cycle, it counts as a single stall cycle.
- Reset asserted mid-MDWAIT forces RUN and mdBusy = 0 immediately, without waiting for a clock edge.
- With MDU_LATENCY = 1, mdBusy is high for exactly one cycle.

## Test plan
- **Load-use stall:** lwEX = 1, GPRWrEX = 1, rdEX = 8, rsID = 8, useRs = 1 in cycle 5 → cycle 5 has PCWr = 0, IFIDWr = 0, IDEXFlush = 1. Cycle 6 (inputs cleared) returns to normal, and stallCnt = 1.
- **$zero and unused operands:** the same as above but rdEX = 0, or useRs = 0 with rtID ≠ 8 → no stall, and stallCnt stays 0.
- **MDU wait:** MDU_LATENCY = 4, mdStartEX in cycle 10, mdUseID = 1 from cycle 11 → mdBusy and stall in cycles 11–14, PCWr = 1 in cycle 15, stallCnt = 4.
- **Branch priority:** branchEX = 1 together with an active ldHaz → PCWr = 1, IFIDWr = 1, IFIDFlush = 1, IDEXFlush = 1, and stallCnt unchanged.
- **Reset mid-operation:** rst_n pulled low in cycle 2 of MDWAIT → mdBusy = 0 and stallCnt = 0 asynchronously. After release, mdUseID causes no stall.
- **Counter saturation:** force 65 540 consecutive load-use stall cycles → stallCnt = 16'hFFFF, with no wrap to 0.
